// File: rtl/kernel_pr_write_back_start_arb_if.sv
// Handshake bundle between the write_back start arbiter and its neighbours:
// per-producer start FIFOs, the shared write_back process and the completion FIFO.
interface kernel_pr_write_back_start_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0] req_empty_n;
    logic [NUM_REQ-1:0] req_read;
    logic               wb_ap_start;
    logic               wb_ap_ready;
    logic               wb_ap_done;
    logic [ID_W-1:0]    wb_src_id;
    logic               done_full_n;
    logic               done_write;
    logic [ID_W-1:0]    done_din;
    logic [2:0]         inflight;
    logic               err;
    logic [31:0]        perf_stall;

    modport master (
        input  req_empty_n, wb_ap_ready, wb_ap_done, done_full_n,
        output req_read, wb_ap_start, wb_src_id, done_write, done_din,
               inflight, err, perf_stall
    );

    modport slave (
        output req_empty_n, wb_ap_ready, wb_ap_done, done_full_n,
        input  req_read, wb_ap_start, wb_src_id, done_write, done_din,
               inflight, err, perf_stall
    );
endinterface

// File: rtl/kernel_pr_write_back_start_arb.sv
// Round-robin start arbiter sharing one write_back process among NUM_REQ producers.
// Optional stall counter enabled by KERNEL_PR_WB_ARB_PERF_EN.
module kernel_pr_write_back_start_arb #(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = 2,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic clk,
    input  logic reset_n,
    kernel_pr_write_back_start_arb_if.master bus
);
    localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

    typedef enum logic [0:0] {IDLE, START} state_t;

    state_t                r_state, w_state_nxt;
    logic [ID_W-1:0]       r_last_grant, r_id, w_grant, w_idx;
    logic                  w_grant_vld, w_take, w_push, w_pop, w_done_ok;
    logic [(1<<ID_W)-1:0]  w_req_ext;
    logic [NUM_REQ-1:0]    w_req_read;
    logic [ID_W-1:0]       r_q [MAX_INFLIGHT];
    logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
    logic [2:0]            r_inflight, r_pend_done;
    logic                  r_done_write, r_err;
    logic [ID_W-1:0]       r_done_din;

    // Search starts one past the last grant and wraps, so every producer gets a turn.
    always_comb begin
        w_req_ext              = '0;
        w_req_ext[NUM_REQ-1:0] = bus.req_empty_n;
        w_grant_vld            = 1'b0;
        w_grant                = '0;
        w_idx                  = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            w_idx = ID_W'((32'(r_last_grant) + i) % NUM_REQ);
            if (!w_grant_vld && w_req_ext[w_idx]) begin
                w_grant_vld = 1'b1;
                w_grant     = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_push      = 1'b0;
        w_req_read  = '0;
        case (r_state)
            IDLE: begin
                if (r_inflight < 3'(MAX_INFLIGHT) && w_grant_vld) begin
                    w_take      = 1'b1;
                    w_req_read  = NUM_REQ'(1) << w_grant;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (bus.wb_ap_ready) begin
                    w_push      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // r_inflight equals the ID queue occupancy; a done is legal only if some
    // queued entry is not already claimed by an earlier pending done.
    assign w_done_ok = bus.wb_ap_done && (r_inflight != r_pend_done);
    assign w_pop     = (r_pend_done != 3'd0) && (r_inflight != 3'd0) && bus.done_full_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_id         <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_inflight   <= '0;
            r_pend_done  <= '0;
            r_done_write <= 1'b0;
            r_done_din   <= '0;
            r_err        <= 1'b0;
            for (int unsigned k = 0; k < MAX_INFLIGHT; k++) r_q[k] <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_done_write <= w_pop;
            if (w_take) r_id <= w_grant;
            if (w_push) begin
                r_q[r_wr_ptr] <= r_id;
                r_last_grant  <= r_id;
                r_wr_ptr      <= (r_wr_ptr == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_done_din <= r_q[r_rd_ptr];
                r_rd_ptr   <= (r_rd_ptr == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop)      r_inflight <= r_inflight + 3'd1;
            else if (w_pop && !w_push) r_inflight <= r_inflight - 3'd1;
            if (w_done_ok && !w_pop)      r_pend_done <= r_pend_done + 3'd1;
            else if (w_pop && !w_done_ok) r_pend_done <= r_pend_done - 3'd1;
            if (bus.wb_ap_done && !w_done_ok) r_err <= 1'b1;
        end
    end

`ifdef KERNEL_PR_WB_ARB_PERF_EN
    logic [31:0] r_perf_stall;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_stall <= '0;
        end else if ((r_state == START && !bus.wb_ap_ready) ||
                     (r_pend_done != 3'd0 && r_inflight != 3'd0 && !bus.done_full_n)) begin
            r_perf_stall <= r_perf_stall + 32'd1;
        end
    end
    assign bus.perf_stall = r_perf_stall;
`else
    assign bus.perf_stall = '0;
`endif

    // req_read is combinational, so it is masked directly by reset to stay low while held.
    assign bus.req_read    = {NUM_REQ{reset_n}} & w_req_read;
    assign bus.wb_ap_start = (r_state == START);
    assign bus.wb_src_id   = r_id;
    assign bus.done_write  = r_done_write;
    assign bus.done_din    = r_done_din;
    assign bus.inflight    = r_inflight;
    assign bus.err         = r_err;
endmodule

// File: tb/tb_kernel_pr_write_back_start_arb.sv
// Directed self-checking bench for kernel_pr_write_back_start_arb (default parameters).
module tb_kernel_pr_write_back_start_arb;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

`ifdef KERNEL_PR_WB_ARB_PERF_EN
    localparam logic [31:0] EXP_STALL7 = 32'd7;
`else
    localparam logic [31:0] EXP_STALL7 = 32'd0;
`endif

    kernel_pr_write_back_start_arb_if #(.NUM_REQ(4), .ID_W(2)) bus ();

    kernel_pr_write_back_start_arb #(
        .NUM_REQ(4),
        .ID_W(2),
        .MAX_INFLIGHT(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n             = 1'b0;
        bus.req_empty_n     = '0;
        bus.wb_ap_ready     = 1'b0;
        bus.wb_ap_done      = 1'b0;
        bus.done_full_n     = 1'b1;
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n         = 1'b0;
        bus.req_empty_n = 4'b1111;
        bus.wb_ap_ready = 1'b0;
        bus.wb_ap_done  = 1'b0;
        bus.done_full_n = 1'b1;
        step();
        step();
        chk("rst_req_read", 32'(bus.req_read), 32'h0);
        chk("rst_start", 32'(bus.wb_ap_start), 32'h0);
        chk("rst_done_write", 32'(bus.done_write), 32'h0);
        chk("rst_inflight", 32'(bus.inflight), 32'h0);
        chk("rst_err", 32'(bus.err), 32'h0);
        chk("rst_perf", bus.perf_stall, 32'h0);
        bus.req_empty_n = '0;
        reset_n = 1'b1;

        // single requester
        bus.req_empty_n = 4'b0001; #1;
        chk("t1_req_read", 32'(bus.req_read), 32'h1);
        step();
        bus.req_empty_n = '0; #1;
        chk("t1_start", 32'(bus.wb_ap_start), 32'h1);
        chk("t1_src", 32'(bus.wb_src_id), 32'h0);
        chk("t1_no_read", 32'(bus.req_read), 32'h0);
        bus.wb_ap_ready = 1'b1;
        step();
        bus.wb_ap_ready = 1'b0; #1;
        chk("t1_start_drop", 32'(bus.wb_ap_start), 32'h0);
        chk("t1_inflight1", 32'(bus.inflight), 32'h1);
        repeat (4) step();
        bus.wb_ap_done = 1'b1;
        step();
        bus.wb_ap_done = 1'b0; #1;
        chk("t1_dw_pre", 32'(bus.done_write), 32'h0);
        step();
        chk("t1_dw", 32'(bus.done_write), 32'h1);
        chk("t1_din", 32'(bus.done_din), 32'h0);
        chk("t1_inflight0", 32'(bus.inflight), 32'h0);
        step();
        chk("t1_dw_end", 32'(bus.done_write), 32'h0);

        // all requesters, round-robin with in-flight limit
        do_reset();
        bus.req_empty_n = 4'b1111;
        bus.wb_ap_ready = 1'b1; #1;
        chk("t2_g0", 32'(bus.req_read), 32'h1);
        step();
        chk("t2_src0", 32'(bus.wb_src_id), 32'h0);
        step();
        chk("t2_g1", 32'(bus.req_read), 32'h2);
        step();
        chk("t2_src1", 32'(bus.wb_src_id), 32'h1);
        step();
        chk("t2_peak", 32'(bus.inflight), 32'h2);
        chk("t2_gated", 32'(bus.req_read), 32'h0);
        bus.wb_ap_done = 1'b1;
        step();
        bus.wb_ap_done = 1'b0; #1;
        chk("t2_gated2", 32'(bus.req_read), 32'h0);
        step();
        chk("t2_dw0", 32'(bus.done_write), 32'h1);
        chk("t2_din0", 32'(bus.done_din), 32'h0);
        chk("t2_g2", 32'(bus.req_read), 32'h4);
        step();
        chk("t2_src2", 32'(bus.wb_src_id), 32'h2);
        step();
        chk("t2_peak2", 32'(bus.inflight), 32'h2);
        bus.wb_ap_done = 1'b1;
        step();
        bus.wb_ap_done = 1'b0;
        step();
        chk("t2_din1", 32'(bus.done_din), 32'h1);
        chk("t2_inflight1", 32'(bus.inflight), 32'h1);
        chk("t2_g3", 32'(bus.req_read), 32'h8);
        step();
        bus.wb_ap_ready = 1'b0;
        bus.wb_ap_done  = 1'b1; #1;
        chk("t2_src3", 32'(bus.wb_src_id), 32'h3);
        step();
        bus.wb_ap_done  = 1'b0;
        bus.wb_ap_ready = 1'b1; #1;
        chk("t2_src3_hold", 32'(bus.wb_ap_start), 32'h1);
        step();
        chk("t2_sim_dw", 32'(bus.done_write), 32'h1);
        chk("t2_sim_din", 32'(bus.done_din), 32'h2);
        chk("t2_sim_inflight", 32'(bus.inflight), 32'h1);
        chk("t2_g0_wrap", 32'(bus.req_read), 32'h1);

        // ready stall
        do_reset();
        bus.req_empty_n = 4'b0001; #1;
        chk("t3_g0", 32'(bus.req_read), 32'h1);
        step();
        bus.req_empty_n = 4'b1111;
        for (int i = 0; i < 7; i++) begin
            #1;
            chk("t3_hold_start", 32'(bus.wb_ap_start), 32'h1);
            chk("t3_hold_src", 32'(bus.wb_src_id), 32'h0);
            chk("t3_hold_noread", 32'(bus.req_read), 32'h0);
            step();
        end
        chk("t3_perf", bus.perf_stall, EXP_STALL7);
        chk("t3_still_start", 32'(bus.wb_ap_start), 32'h1);
        bus.wb_ap_ready = 1'b1;
        step();
        chk("t3_perf_after", bus.perf_stall, EXP_STALL7);
        chk("t3_inflight", 32'(bus.inflight), 32'h1);
        chk("t3_start_drop", 32'(bus.wb_ap_start), 32'h0);

        // completion back-pressure
        do_reset();
        bus.req_empty_n = 4'b0011;
        bus.wb_ap_ready = 1'b1; #1;
        chk("t4_g0", 32'(bus.req_read), 32'h1);
        step();
        step();
        chk("t4_g1", 32'(bus.req_read), 32'h2);
        step();
        bus.req_empty_n = '0;
        step();
        chk("t4_inflight2", 32'(bus.inflight), 32'h2);
        bus.done_full_n = 1'b0;
        bus.wb_ap_done  = 1'b1;
        step();
        bus.wb_ap_done = 1'b0;
        step();
        bus.wb_ap_done = 1'b1;
        step();
        bus.wb_ap_done = 1'b0; #1;
        chk("t4_held", 32'(bus.done_write), 32'h0);
        step();
        chk("t4_held2", 32'(bus.done_write), 32'h0);
        chk("t4_held_inflight", 32'(bus.inflight), 32'h2);
        bus.done_full_n = 1'b1;
        step();
        chk("t4_dw_a", 32'(bus.done_write), 32'h1);
        chk("t4_din_a", 32'(bus.done_din), 32'h0);
        chk("t4_inflight_a", 32'(bus.inflight), 32'h1);
        step();
        chk("t4_dw_b", 32'(bus.done_write), 32'h1);
        chk("t4_din_b", 32'(bus.done_din), 32'h1);
        chk("t4_inflight_b", 32'(bus.inflight), 32'h0);
        step();
        chk("t4_dw_end", 32'(bus.done_write), 32'h0);

        // spurious done sets sticky error
        bus.wb_ap_done = 1'b1;
        step();
        bus.wb_ap_done = 1'b0; #1;
        chk("t5_err", 32'(bus.err), 32'h1);
        chk("t5_inflight", 32'(bus.inflight), 32'h0);
        repeat (3) step();
        chk("t5_err_sticky", 32'(bus.err), 32'h1);
        chk("t5_no_dw", 32'(bus.done_write), 32'h0);
        reset_n = 1'b0; #1;
        chk("t5_err_clr", 32'(bus.err), 32'h0);
        step();
        reset_n = 1'b1;

        // reset while START is active
        bus.req_empty_n = 4'b0100;
        bus.wb_ap_ready = 1'b1; #1;
        chk("t6_g2", 32'(bus.req_read), 32'h4);
        step();
        step();
        step();
        bus.wb_ap_ready = 1'b0; #1;
        chk("t6_start", 32'(bus.wb_ap_start), 32'h1);
        chk("t6_src", 32'(bus.wb_src_id), 32'h2);
        chk("t6_inflight", 32'(bus.inflight), 32'h1);
        reset_n = 1'b0; #1;
        chk("t6_rst_start", 32'(bus.wb_ap_start), 32'h0);
        chk("t6_rst_read", 32'(bus.req_read), 32'h0);
        chk("t6_rst_dw", 32'(bus.done_write), 32'h0);
        chk("t6_rst_inflight", 32'(bus.inflight), 32'h0);
        bus.req_empty_n = 4'b1111;
        step();
        reset_n = 1'b1; #1;
        chk("t6_first_g0", 32'(bus.req_read), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
